// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// Kept separate so the arbiter and the round-robin selector agree on encodings.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
// Purely combinational; the owner history lives in the arbiter.
module mem_arb_rr (
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic grant_valid,
   output logic grant_idx
);

   always_comb begin
      grant_valid = req0 | req1;
      if (req0 && req1) begin
         grant_idx = ~last_owner;
      end else begin
         grant_idx = req1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-cache port (0) and a data-cache port (1) onto one
// memory channel with a three-state IDLE/BUSY/DONE transaction sequencer.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_data_i,
   output logic [DATA_W-1:0] p0_data_o,
   output logic              p0_ack_o,

   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_data_i,
   output logic [DATA_W-1:0] p1_data_o,
   output logic              p1_ack_o,

   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,

   output logic [1:0]        grant_o,
   output logic              err_o
);

   state_t            state_q, state_d;
   logic              owner_q;
   logic              last_owner_q;
   logic              lat_write_q;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [DATA_W-1:0] lat_data_q;
   logic [DATA_W-1:0] p0_line_q, p1_line_q;
   logic              err_q;

   logic              grant_valid;
   logic              grant_idx;
   logic              take_grant;
   logic              done_ack;
   logic              owner_enable;
   logic              err_set;

   mem_arb_rr u_rr (
      .req0        (p0_enable_i),
      .req1        (p1_enable_i),
      .last_owner  (last_owner_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   assign take_grant   = (state_q == IDLE) && grant_valid;
   assign done_ack     = (state_q == BUSY) && mem_ack_i;
   assign owner_enable = owner_q ? p1_enable_i : p0_enable_i;
   // Stray acks outside BUSY and an owner abandoning its request both flag errors.
   assign err_set      = (mem_ack_i && (state_q != BUSY)) ||
                         ((state_q == BUSY) && !owner_enable);

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid) state_d = BUSY;
         BUSY:    if (mem_ack_i)   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         lat_write_q  <= 1'b0;
         lat_addr_q   <= '0;
         lat_data_q   <= '0;
         p0_line_q    <= '0;
         p1_line_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take_grant) begin
            owner_q      <= grant_idx;
            last_owner_q <= grant_idx;
            lat_write_q  <= grant_idx ? p1_write_i : p0_write_i;
            lat_addr_q   <= grant_idx ? p1_addr_i  : p0_addr_i;
            lat_data_q   <= grant_idx ? p1_data_i  : p0_data_i;
         end
         if (done_ack && !owner_q) p0_line_q <= mem_data_i;
         if (done_ack &&  owner_q) p1_line_q <= mem_data_i;
         if (err_set)              err_q     <= 1'b1;
      end
   end

   // The memory side only sees the latched request while BUSY; otherwise it is quiet.
   always_comb begin
      mem_enable_o = (state_q == BUSY);
      mem_write_o  = (state_q == BUSY) ? lat_write_q : 1'b0;
      mem_addr_o   = (state_q == BUSY) ? lat_addr_q  : '0;
      mem_data_o   = (state_q == BUSY) ? lat_data_q  : '0;
   end

   always_comb begin
      p0_ack_o  = done_ack && !owner_q;
      p1_ack_o  = done_ack &&  owner_q;
      p0_data_o = p0_ack_o ? mem_data_i : p0_line_q;
      p1_data_o = p1_ack_o ? mem_data_i : p1_line_q;
      grant_o   = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
      err_o     = err_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-port transactions plus
// hand-written sequences for ties, fairness, stray acks and mid-transaction reset.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 256;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
   logic [AW-1:0] p0_addr_i, p1_addr_i, mem_addr_o;
   logic [DW-1:0] p0_data_i, p1_data_i, p0_data_o, p1_data_o;
   logic [DW-1:0] mem_data_o, mem_data_i;
   logic          p0_ack_o, p1_ack_o, mem_enable_o, mem_write_o, mem_ack_i;
   logic [1:0]    grant_o;
   logic          err_o;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] last_data [2];

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .p0_enable_i  (p0_enable_i),
      .p0_write_i   (p0_write_i),
      .p0_addr_i    (p0_addr_i),
      .p0_data_i    (p0_data_i),
      .p0_data_o    (p0_data_o),
      .p0_ack_o     (p0_ack_o),
      .p1_enable_i  (p1_enable_i),
      .p1_write_i   (p1_write_i),
      .p1_addr_i    (p1_addr_i),
      .p1_data_i    (p1_data_i),
      .p1_data_o    (p1_data_o),
      .p1_ack_o     (p1_ack_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i),
      .grant_o      (grant_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit            port;
      bit            write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            delay;
      logic [1:0]    exp_grant;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_port(input bit port, input bit en, input bit wr,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if (port) begin
         p1_enable_i = en; p1_write_i = wr; p1_addr_i = addr; p1_data_i = data;
      end else begin
         p0_enable_i = en; p0_write_i = wr; p0_addr_i = addr; p0_data_i = data;
      end
   endtask

   task automatic wait_enable(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_i);
         if (mem_enable_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Pulse mem_ack_i in the second half of the current cycle and check routing.
   task automatic ack_and_check(input string tag, input bit port, input logic [DW-1:0] rd);
      mem_data_i = rd;
      mem_ack_i  = 1'b1;
      #1;
      check({tag, "_own_ack"},   256'(port ? p1_ack_o : p0_ack_o), 256'(1));
      check({tag, "_other_ack"}, 256'(port ? p0_ack_o : p1_ack_o), 256'(0));
      check({tag, "_own_data"},  port ? p1_data_o : p0_data_o, rd);
      check({tag, "_other_data"}, port ? p0_data_o : p1_data_o, last_data[!port]);
      last_data[port] = rd;
   endtask

   initial begin
      bit ok;

      vecs[0] = '{port: 1'b0, write: 1'b0, addr: 32'h0000_0400, wdata: {8{32'h1111_2222}},
                  rdata: {8{32'hDEAD_BEEF}}, delay: 10, exp_grant: 2'b01};
      vecs[1] = '{port: 1'b1, write: 1'b1, addr: 32'h0000_0800, wdata: {32{8'hA5}},
                  rdata: {8{32'h0BAD_F00D}}, delay: 3, exp_grant: 2'b10};
      vecs[2] = '{port: 1'b1, write: 1'b0, addr: 32'h1234_5678, wdata: {8{32'h3333_4444}},
                  rdata: {8{32'hCAFE_0001}}, delay: 0, exp_grant: 2'b10};
      vecs[3] = '{port: 1'b0, write: 1'b1, addr: 32'hFFFF_FFC0, wdata: {DW{1'b1}},
                  rdata: {8{32'h5555_AAAA}}, delay: 1, exp_grant: 2'b01};
      vecs[4] = '{port: 1'b1, write: 1'b0, addr: 32'h0000_0000, wdata: {8{32'h7777_8888}},
                  rdata: {8{32'h1357_9BDF}}, delay: 2, exp_grant: 2'b10};

      rst_i = 1'b0;
      p0_enable_i = 0; p0_write_i = 0; p0_addr_i = '0; p0_data_i = '0;
      p1_enable_i = 0; p1_write_i = 0; p1_addr_i = '0; p1_data_i = '0;
      mem_ack_i = 0; mem_data_i = '0;
      last_data[0] = '0;
      last_data[1] = '0;

      // Reset state.
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_mem_en",  256'(mem_enable_o), 256'(0));
      check("rst_grant",   256'(grant_o),      256'(0));
      check("rst_err",     256'(err_o),        256'(0));
      check("rst_p0_data", p0_data_o,          '0);
      check("rst_mem_addr", 256'(mem_addr_o),  256'(0));
      rst_i = 1'b1;

      // Tie straight after reset: port 0 first, then port 1.
      @(negedge clk_i);
      drive_port(0, 1, 0, 32'h10, '0);
      drive_port(1, 1, 0, 32'h20, '0);
      tick();
      @(negedge clk_i);
      check("tie_first_grant", 256'(grant_o),    256'(2'b01));
      check("tie_first_addr",  256'(mem_addr_o), 256'(32'h10));
      ack_and_check("tie_first", 0, {8{32'hA0A0_0001}});
      tick();
      mem_ack_i = 0;
      p0_enable_i = 0;
      @(negedge clk_i);
      check("tie_done_grant",  256'(grant_o),      256'(2'b01));
      check("tie_done_mem_en", 256'(mem_enable_o), 256'(0));
      check("tie_done_ack",    256'(p0_ack_o | p1_ack_o), 256'(0));
      tick();
      @(negedge clk_i);
      check("tie_idle_grant",  256'(grant_o),      256'(0));
      check("tie_idle_mem_en", 256'(mem_enable_o), 256'(0));
      tick();
      @(negedge clk_i);
      check("tie_second_grant", 256'(grant_o),    256'(2'b10));
      check("tie_second_addr",  256'(mem_addr_o), 256'(32'h20));
      ack_and_check("tie_second", 1, {8{32'hB0B0_0002}});
      tick();
      mem_ack_i = 0;
      p1_enable_i = 0;
      tick();

      // Table of single-port transactions.
      for (int v = 0; v < 5; v++) begin
         @(negedge clk_i);
         drive_port(vecs[v].port, 1, vecs[v].write, vecs[v].addr, vecs[v].wdata);
         tick();
         @(negedge clk_i);
         check($sformatf("v%0d_lat_en", v), 256'(mem_enable_o), 256'(1));
         check($sformatf("v%0d_grant", v),  256'(grant_o),      256'(vecs[v].exp_grant));
         for (int k = 0; k < vecs[v].delay; k++) begin
            tick();
            @(negedge clk_i);
            check($sformatf("v%0d_en_c%0d", v, k), 256'(mem_enable_o), 256'(1));
         end
         check($sformatf("v%0d_write", v), 256'(mem_write_o), 256'(vecs[v].write));
         check($sformatf("v%0d_addr", v),  256'(mem_addr_o),  256'(vecs[v].addr));
         check($sformatf("v%0d_wdata", v), mem_data_o,        vecs[v].wdata);
         check($sformatf("v%0d_early_ack", v), 256'(p0_ack_o | p1_ack_o), 256'(0));
         ack_and_check($sformatf("v%0d", v), vecs[v].port, vecs[v].rdata);
         tick();
         mem_ack_i = 0;
         drive_port(vecs[v].port, 0, 0, '0, '0);
         @(negedge clk_i);
         check($sformatf("v%0d_done_en", v),   256'(mem_enable_o), 256'(0));
         check($sformatf("v%0d_done_gnt", v),  256'(grant_o),      256'(vecs[v].exp_grant));
         check($sformatf("v%0d_hold", v), vecs[v].port ? p1_data_o : p0_data_o, vecs[v].rdata);
         tick();
         @(negedge clk_i);
         check($sformatf("v%0d_idle_gnt", v),  256'(grant_o),      256'(0));
         check($sformatf("v%0d_idle_addr", v), 256'(mem_addr_o),   256'(0));
      end

      // Both ports request continuously: grants must alternate, p0 first (p1 won last).
      @(negedge clk_i);
      drive_port(0, 1, 0, 32'h100, '0);
      drive_port(1, 1, 0, 32'h200, '0);
      for (int i = 0; i < 6; i++) begin
         wait_enable(ok);
         check($sformatf("rr%0d_wait", i), 256'(ok), 256'(1));
         check($sformatf("rr%0d_grant", i), 256'(grant_o), 256'((i % 2) ? 2'b10 : 2'b01));
         ack_and_check($sformatf("rr%0d", i), bit'(i % 2), {8{32'hC000_0000 + 32'(i)}});
         tick();
         mem_ack_i = 0;
      end
      @(negedge clk_i);
      p0_enable_i = 0;
      p1_enable_i = 0;
      tick();
      tick();
      check("rr_err_clean", 256'(err_o), 256'(0));

      // Stray ack while idle: ignored for routing, error flag sticks.
      @(negedge clk_i);
      mem_data_i = {8{32'hEEEE_EEEE}};
      mem_ack_i  = 1'b1;
      #1;
      check("stray_p0_ack",  256'(p0_ack_o), 256'(0));
      check("stray_p1_ack",  256'(p1_ack_o), 256'(0));
      check("stray_p0_data", p0_data_o, last_data[0]);
      check("stray_p1_data", p1_data_o, last_data[1]);
      tick();
      mem_ack_i = 0;
      @(negedge clk_i);
      check("stray_err_set", 256'(err_o), 256'(1));
      check("stray_no_busy", 256'(mem_enable_o), 256'(0));
      repeat (3) tick();
      check("stray_err_sticky", 256'(err_o), 256'(1));

      // Reset in the middle of BUSY clears everything immediately.
      @(negedge clk_i);
      drive_port(0, 1, 1, 32'h40, {8{32'h9999_0000}});
      tick();
      @(negedge clk_i);
      check("mid_busy_en", 256'(mem_enable_o), 256'(1));
      #2;
      rst_i = 1'b0;
      #1;
      check("mid_rst_en",      256'(mem_enable_o), 256'(0));
      check("mid_rst_write",   256'(mem_write_o),  256'(0));
      check("mid_rst_grant",   256'(grant_o),      256'(0));
      check("mid_rst_err",     256'(err_o),        256'(0));
      check("mid_rst_addr",    256'(mem_addr_o),   256'(0));
      check("mid_rst_mdata",   mem_data_o,         '0);
      check("mid_rst_p0_data", p0_data_o,          '0);
      check("mid_rst_p1_data", p1_data_o,          '0);
      p0_enable_i = 0;
      last_data[0] = '0;
      last_data[1] = '0;
      tick();
      rst_i = 1'b1;
      @(negedge clk_i);
      drive_port(1, 1, 0, 32'h80, '0);
      tick();
      @(negedge clk_i);
      check("post_rst_grant", 256'(grant_o),    256'(2'b10));
      check("post_rst_addr",  256'(mem_addr_o), 256'(32'h80));
      ack_and_check("post_rst", 1, {8{32'h2468_ACE0}});
      tick();
      mem_ack_i = 0;
      p1_enable_i = 0;
      tick();
      tick();
      check("post_rst_err", 256'(err_o), 256'(0));

      // Owner drops enable mid-BUSY: transaction still completes, error flagged.
      @(negedge clk_i);
      drive_port(0, 1, 0, 32'hC0, '0);
      tick();
      @(negedge clk_i);
      p0_enable_i = 0;
      tick();
      @(negedge clk_i);
      check("drop_still_busy", 256'(mem_enable_o), 256'(1));
      check("drop_err",        256'(err_o),        256'(1));
      ack_and_check("drop", 0, {8{32'h600D_D00D}});
      tick();
      mem_ack_i = 0;
      tick();
      check("drop_idle_grant", 256'(grant_o), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, memory address width.
REQ-002 Parameter DATA_W, 256, memory line width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  system clock; all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous active-low reset.
REQ-006 p0_enable_i  input  1  instruction-cache request; held high until p0_ack_o.
REQ-007 p0_write_i  input  1  port-0 write (1) / read (0).
REQ-008 p0_addr_i  input  ADDR_W  port-0 line address.
REQ-009 p0_data_i  input  DATA_W  port-0 write line.
REQ-010 p0_data_o  output  DATA_W  port-0 read line.
REQ-011 p0_ack_o  output  1  port-0 completion pulse.
REQ-012 p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: data-cache port with the same directions, widths and meanings as port 0.
REQ-013 mem_enable_o  output  1  memory request, held until mem_ack_i.
REQ-014 mem_write_o  output  1  memory write select.
REQ-015 mem_addr_o  output  ADDR_W  memory address.
REQ-016 mem_data_o  output  DATA_W  memory write line.
REQ-017 mem_data_i  input  DATA_W  memory read line.
REQ-018 mem_ack_i  input  1  memory completion pulse.
REQ-019 grant_o  output  2  one-hot current owner; 00 when idle.
REQ-020 err_o  output  1  sticky protocol-error flag.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-022 In IDLE with no enable high, the FSM SHALL stay in IDLE with all mem_* outputs 0.
REQ-023 In IDLE with exactly one enable high, that port SHALL be granted and the FSM SHALL enter BUSY on the next edge.
REQ-024 In IDLE with both enables high, the port not equal to last_owner SHALL be granted (round-robin).
REQ-025 On grant, the owner's write, addr and data SHALL be latched, and last_owner SHALL be updated to the owner.
REQ-026 In BUSY, mem_enable_o SHALL be 1 and mem_write_o/addr/data SHALL come from the latched values, so latency is one cycle from request sample to mem_enable_o.
REQ-027 In BUSY, mem_ack_i=1 SHALL assert the owner's ack for exactly that cycle (combinational), drive mem_data_i onto the owner's data_o, and move the FSM to DONE.
REQ-028 A non-owner's ack SHALL never assert; each data_o SHALL hold the last line delivered to that port.
REQ-029 DONE SHALL last one cycle, with mem_enable_o=0 and enables ignored, then return to IDLE; back-to-back transactions are therefore 1 idle cycle apart at minimum.
REQ-030 An owner dropping enable during BUSY SHALL NOT abort the transaction; it completes, the ack is still pulsed, and err_o is set.
REQ-031 mem_ack_i=1 in IDLE or DONE SHALL be ignored for routing and SHALL set err_o.
REQ-032 err_o SHALL clear only on reset.
REQ-033 Fairness: a continuously requesting port SHALL be granted within at most one foreign transaction.
REQ-034 grant_o SHALL equal the one-hot owner in BUSY and DONE, and 00 in IDLE.

Reset
REQ-035 Asserting rst_i (low) SHALL, asynchronously and at any point including mid-BUSY, force: IDLE; mem_enable_o, mem_write_o, acks, grant_o, err_o to 0; mem_addr_o, mem_data_o, p0_data_o, p1_data_o to 0; last_owner to 1, so port 0 wins the first tie.
REQ-036 After rst_i deasserts, the first grant SHALL follow REQ-023/024 with no extra delay cycles.

Structure
REQ-037 Shared package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the ADDR_W/DATA_W defaults.
REQ-038 Round-robin selection SHALL live in sub-module mem_arb_rr (inputs: two requests and last_owner; outputs: grant valid and index), which is purely combinational.
REQ-039 All other state SHALL be in mem_arbiter; no other sub-modules.

Verification
REQ-040 p0 read addr 0x0000_0400, mem_ack_i 10 cycles after mem_enable_o -> mem_enable_o high cycle 1; one p0_ack_o pulse with p0_data_o = mem_data_i; p1_ack_o stays 0.
REQ-041 Both enables high immediately after reset -> p0 served first, p1 second, with exactly one DONE cycle between the two transactions.
REQ-042 Both ports request continuously for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1.
REQ-043 p1 write addr 0x0000_0800, data all-0xA5 -> mem_write_o=1, mem_addr_o=0x800, mem_data_o=all-0xA5 stable through BUSY.
REQ-044 Spurious mem_ack_i while in IDLE -> no ack to either port; err_o=1 and remains 1 until reset.
REQ-045 rst_i pulsed low mid-BUSY -> all outputs 0 immediately; after release a p1-only request is granted normally.
